// File: rtl/descrambler_pkg.sv
// -----------------------------------------------------------------------------
// descrambler_pkg
//   Shared main-link scrambling definitions. The scrambler and the descrambler
//   both import this package, so the two ends of the link stay bit-for-bit
//   identical.
//
//   Contents:
//     SYM_SR, SYM_BS         K-code values for the scrambler reset (K28.0) and
//                            the blanking start (K28.5) symbols
//     LFSR_SEED, LFSR_TAPS   seed value and Galois tap mask for the polynomial
//                            x^16 + x^5 + x^4 + x^3 + 1
//     ST_HUNT, ST_LOCKED     encodings of the lock FSM states
//     lfsr_step_t            result of one symbol step: next state and key byte
//     lfsr_step8()           advances the LFSR by 8 bits and returns the key
// -----------------------------------------------------------------------------
package descrambler_pkg;

    localparam logic [7:0]  SYM_SR    = 8'h1C;
    localparam logic [7:0]  SYM_BS    = 8'hBC;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS = 16'h0039;

    // The lock FSM states are plain constants so that older tools and
    // netlists that expect a raw state vector can still use them.
    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef struct packed {
        logic [15:0] state;
        logic [7:0]  key;
    } lfsr_step_t;

    // One symbol worth of keystream. Key bit i is the LFSR MSB before the
    // i-th shift, and it is applied to data bit i (bit 0 first on the wire).
    function automatic lfsr_step_t lfsr_step8(input logic [15:0] state);
        lfsr_step_t res;
        logic [15:0] s;
        // NOTE: blocking assignments here are intentional. Each loop
        // iteration must see the value produced by the previous one.
        s       = state;
        res.key = '0;
        for (int i = 0; i < 8; i++) begin
            res.key[i] = s[15];
            s = {s[14:0], 1'b0} ^ (s[15] ? LFSR_TAPS : 16'h0000);
        end
        res.state = s;
        return res;
    endfunction

endpackage

// File: rtl/descrambler_sym.sv
// -----------------------------------------------------------------------------
// descrambler_sym
//   Purely combinational descrambling of one 8-bit symbol. The top instantiates
//   two copies and chains them: the low symbol's lfsr_out feeds the high
//   symbol's lfsr_in.
//
//   Ports:
//     dat      in   8   received (scrambled) symbol
//     isk      in   1   K flag for dat
//     lfsr_in  in   16  LFSR state seen by this symbol
//     dat_out  out  8   descrambled symbol (K symbols pass unchanged)
//     lfsr_out out  16  LFSR state handed to the next symbol
//     is_sr    out  1   dat is SR (K28.0)
//     is_bs    out  1   dat is BS (K28.5)
// -----------------------------------------------------------------------------
module descrambler_sym
    import descrambler_pkg::*;
(
    input  logic [7:0]  dat,
    input  logic        isk,
    input  logic [15:0] lfsr_in,
    output logic [7:0]  dat_out,
    output logic [15:0] lfsr_out,
    output logic        is_sr,
    output logic        is_bs
);

    lfsr_step_t step;

    always_comb begin
        step  = lfsr_step8(lfsr_in);
        is_sr = isk && (dat == SYM_SR);
        is_bs = isk && (dat == SYM_BS);

        // K symbols are never scrambled. Non-SR K codes still consume 8 key
        // bits, so the data that follows stays in step with the scrambler.
        dat_out = isk ? dat : (dat ^ step.key);

        // SR reseeds without advancing, so the very next symbol (even the high
        // symbol of this same cycle) is keyed from the fresh seed.
        lfsr_out = is_sr ? LFSR_SEED : step.state;
    end

endmodule

// File: rtl/descrambler.sv
// -----------------------------------------------------------------------------
// descrambler
//   Sink-side inverse of the per-lane scrambler. It recovers the plain
//   main-link symbols from one lane's scrambled stream (2 symbols per cycle)
//   and tracks SR alignment. Descrambling runs whether or not the block is
//   locked; locked only qualifies the output. Latency is one cycle and the
//   block never stalls.
//
//   Parameters:
//     BSMAX    number of BS symbols tolerated since the last SR before lock is
//              dropped
//
//   Ports:
//     dpclk    in   1   link clock, all logic on posedge
//     reset    in   1   asynchronous, active-high
//     indat    in   16  scrambled symbols, [7:0] first, [15:8] second
//     inisk    in   2   K flags, bit0 <-> [7:0], bit1 <-> [15:8]
//     outdat   out  16  descrambled symbols, same lane order
//     outisk   out  2   inisk delayed to align with outdat
//     locked   out  1   SR seen and BS budget not exceeded
//     srseen   out  1   one-cycle pulse with outdat when either symbol was SR
// -----------------------------------------------------------------------------
module descrambler
    import descrambler_pkg::*;
#(
    parameter int BSMAX = 520
) (
    input  logic        dpclk,
    input  logic        reset,
    input  logic [15:0] indat,
    input  logic [1:0]  inisk,
    output logic [15:0] outdat,
    output logic [1:0]  outisk,
    output logic        locked,
    output logic        srseen
);

    // The counter must be able to hold BSMAX+2, because up to two BS
    // symbols can arrive in the cycle that crosses the limit.
    localparam int               CNT_W    = $clog2(BSMAX + 3);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] BS_LIMIT = CNT_W'(BSMAX);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [15:0]      lfsr_q,   lfsr_d;
    logic [15:0]      outdat_q, outdat_d;
    logic [1:0]       outisk_q, outisk_d;
    logic             locked_q, locked_d;
    logic             srseen_q, srseen_d;
    logic [0:0]       state_q,  state_d;
    logic [CNT_W-1:0] bscnt_q,  bscnt_d;

    // -------------------------------------------------------------------------
    // Per-symbol descrambling, low symbol first
    // -------------------------------------------------------------------------
    logic [7:0]  lo_dat, hi_dat;
    logic [15:0] lo_lfsr, hi_lfsr;
    logic        lo_sr, lo_bs, hi_sr, hi_bs;

    descrambler_sym u_sym_lo (
        .dat      (indat[7:0]),
        .isk      (inisk[0]),
        .lfsr_in  (lfsr_q),
        .dat_out  (lo_dat),
        .lfsr_out (lo_lfsr),
        .is_sr    (lo_sr),
        .is_bs    (lo_bs)
    );

    descrambler_sym u_sym_hi (
        .dat      (indat[15:8]),
        .isk      (inisk[1]),
        .lfsr_in  (lo_lfsr),
        .dat_out  (hi_dat),
        .lfsr_out (hi_lfsr),
        .is_sr    (hi_sr),
        .is_bs    (hi_bs)
    );

    // -------------------------------------------------------------------------
    // Lock FSM and BS budget counter
    // -------------------------------------------------------------------------
    logic             any_sr;
    logic [1:0]       bs_add;
    logic [CNT_W:0]   bscnt_sum;

    always_comb begin
        // NOTE: every _d signal gets a default before any branch. That way no
        // path leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        bscnt_d  = bscnt_q;

        any_sr    = lo_sr | hi_sr;
        bs_add    = {1'b0, lo_bs} + {1'b0, hi_bs};
        bscnt_sum = {1'b0, bscnt_q} + {{(CNT_W-1){1'b0}}, bs_add};

        case (state_q)
            ST_LOCKED: begin
                if (any_sr) begin
                    // SR wins over any BS in the same cycle.
                    bscnt_d = '0;
                end else begin
                    if (bscnt_sum > {1'b0, CNT_MAX}) begin
                        bscnt_d = CNT_MAX;
                    end else begin
                        bscnt_d = bscnt_sum[CNT_W-1:0];
                    end
                    if (bscnt_d > BS_LIMIT) begin
                        state_d = ST_HUNT;
                    end
                end
            end
            default: begin
                if (any_sr) begin
                    state_d = ST_LOCKED;
                    bscnt_d = '0;
                end
            end
        endcase

        // The status outputs reflect the state after this cycle's symbols.
        // They are therefore registered alongside the data that caused them.
        locked_d = (state_d == ST_LOCKED);
        srseen_d = any_sr;

        outdat_d = {hi_dat, lo_dat};
        outisk_d = inisk;
        lfsr_d   = hi_lfsr;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge dpclk or posedge reset) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            outdat_q <= '0;
            outisk_q <= '0;
            locked_q <= 1'b0;
            srseen_q <= 1'b0;
            state_q  <= ST_HUNT;
            bscnt_q  <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            outdat_q <= outdat_d;
            outisk_q <= outisk_d;
            locked_q <= locked_d;
            srseen_q <= srseen_d;
            state_q  <= state_d;
            bscnt_q  <= bscnt_d;
        end
    end

    assign outdat = outdat_q;
    assign outisk = outisk_q;
    assign locked = locked_q;
    assign srseen = srseen_q;

endmodule
